// File: rtl/vec_argmax.sv
// Streaming argmax over a signed 8-bit vector.
// The vector is read chunk by chunk from an upstream FIFO that has a one-cycle read latency.
module vec_argmax #(
  parameter int InVecLength = 8,
  parameter int WorkingRegs = 8
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             in_data_ready,
  input  logic [WorkingRegs-1:0][7:0]      in_data,
  output logic                             req_chunk_in,
  output logic                             req_chunk_ptr_rst,
  output logic [$clog2(InVecLength)-1:0]   argmax_idx,
  output logic signed [7:0]                argmax_val,
  output logic                             out_vector_valid
);

  localparam int NumChunks = InVecLength / WorkingRegs;
  localparam int IdxW      = $clog2(InVecLength);
  localparam int CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  typedef enum logic [1:0] {IDLE, REQ, CMP, DONE} state_e;

  state_e            state_q;
  logic              pending_q;
  logic [CntW-1:0]   cnt_q;
  logic signed [7:0] max_q;
  logic [IdxW-1:0]   idx_q;

  logic signed [7:0] max_d;
  logic [IdxW-1:0]   idx_d;
  logic [IdxW-1:0]   chunk_base;
  logic              last_chunk;

  assign chunk_base = IdxW'(int'(cnt_q) * WorkingRegs);
  assign last_chunk = (int'(cnt_q) == NumChunks - 1);

  // Scan in ascending index order with a strict compare so ties keep the lowest index.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    for (int k = 0; k < WorkingRegs; k++) begin
      if ($signed(in_data[k]) > max_d) begin
        max_d = $signed(in_data[k]);
        idx_d = chunk_base + IdxW'(k);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q           <= IDLE;
      pending_q         <= 1'b0;
      cnt_q             <= '0;
      max_q             <= 8'sh80;
      idx_q             <= '0;
      argmax_idx        <= '0;
      argmax_val        <= '0;
      out_vector_valid  <= 1'b0;
      req_chunk_in      <= 1'b0;
      req_chunk_ptr_rst <= 1'b0;
    end else begin
      req_chunk_in      <= 1'b0;
      req_chunk_ptr_rst <= 1'b0;
      out_vector_valid  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          max_q <= 8'sh80;
          idx_q <= '0;
          cnt_q <= '0;
          if (in_data_ready) begin
            state_q      <= REQ;
            req_chunk_in <= 1'b1;
          end
        end
        REQ: begin
          if (in_data_ready) pending_q <= 1'b1;
          state_q <= CMP;
        end
        CMP: begin
          if (in_data_ready) pending_q <= 1'b1;
          max_q <= max_d;
          idx_q <= idx_d;
          // The final chunk result goes straight to the outputs so they are valid in DONE.
          if (last_chunk) begin
            state_q           <= DONE;
            argmax_idx        <= idx_d;
            argmax_val        <= max_d;
            out_vector_valid  <= 1'b1;
            req_chunk_ptr_rst <= 1'b1;
          end else begin
            cnt_q        <= cnt_q + CntW'(1);
            state_q      <= REQ;
            req_chunk_in <= 1'b1;
          end
        end
        DONE: begin
          if (pending_q || in_data_ready) begin
            state_q      <= REQ;
            req_chunk_in <= 1'b1;
            pending_q    <= 1'b0;
            max_q        <= 8'sh80;
            idx_q        <= '0;
            cnt_q        <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  a_req_not_with_rewind: assert property (@(posedge clk_in) disable iff (!rst_in)
    !(req_chunk_in && req_chunk_ptr_rst));
  a_req_not_back_to_back: assert property (@(posedge clk_in) disable iff (!rst_in)
    req_chunk_in |=> !req_chunk_in);

endmodule

// File: tb/tb_vec_argmax.sv
// Bench for vec_argmax: two configurations (8x8 single chunk, 8x4 two chunks), each with an
// upstream FIFO model, a request-level reference model, and a scoreboard monitor.
module tb_vec_argmax;
  localparam int L = 8;

  typedef struct {
    int cyc;
    int idx;
    int val;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int errors = 0;
  int checks = 0;

  function automatic logic [L-1:0][7:0] mk(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
    logic [L-1:0][7:0] v;
    v[0] = 8'(a0); v[1] = 8'(a1); v[2] = 8'(a2); v[3] = 8'(a3);
    v[4] = 8'(a4); v[5] = 8'(a5); v[6] = 8'(a6); v[7] = 8'(a7);
    return v;
  endfunction

  function automatic logic [L-1:0][7:0] rand_vec();
    logic [L-1:0][7:0] v;
    int mode;
    int base;
    mode = int'($urandom % 4);
    base = int'($urandom % 256);
    for (int i = 0; i < L; i++) begin
      case (mode)
        0:       v[i] = 8'(int'($urandom_range(0, 3)) - 2);
        1:       v[i] = 8'(base);
        2:       v[i] = 8'($urandom % 256);
        default: v[i] = ($urandom % 2 == 0) ? 8'h80 : 8'h7f;
      endcase
    end
    return v;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int WR = (gi == 0) ? 8 : 4;
    localparam int C  = L / WR;

    logic              rst_n;
    logic              rdy;
    logic              req;
    logic              ptr_rst;
    logic              vld;
    logic [WR-1:0][7:0] data;
    logic [2:0]        idx;
    logic signed [7:0] val;
    bit                done_flag = 1'b0;

    exp_t              exp_q[$];
    int                req_q[$];
    logic [L-1:0][7:0] fifo_q[$];
    int                outstanding = 0;
    int                rdptr = 0;
    int                last_ev = -1000;
    int                last_idx = 0;
    int                last_val = 0;

    vec_argmax #(.InVecLength(L), .WorkingRegs(WR)) u_dut (
      .clk_in            (clk),
      .rst_in            (rst_n),
      .in_data_ready     (rdy),
      .in_data           (data),
      .req_chunk_in      (req),
      .req_chunk_ptr_rst (ptr_rst),
      .argmax_idx        (idx),
      .argmax_val        (val),
      .out_vector_valid  (vld)
    );

    // Reference: one vector in flight plus one waiting; a new one starts when the
    // previous result is presented, or immediately if idle.
    function automatic void accept(input logic [L-1:0][7:0] v);
      int best_i;
      int best_v;
      int s;
      exp_t e;
      if (outstanding >= 2) begin
        $display("cfg%0d cyc %0d: request dropped (one already waiting)", gi, cyc);
        return;
      end
      best_i = 0;
      best_v = $signed(v[0]);
      for (int i = 1; i < L; i++) begin
        if ($signed(v[i]) > best_v) begin
          best_v = $signed(v[i]);
          best_i = i;
        end
      end
      s = (last_ev > cyc) ? last_ev : cyc;
      last_ev = s + 2 * C + 1;
      for (int j = 0; j < C; j++) req_q.push_back(s + 1 + 2 * j);
      e.cyc = last_ev;
      e.idx = best_i;
      e.val = best_v;
      exp_q.push_back(e);
      fifo_q.push_back(v);
      outstanding++;
    endfunction

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic idle(input int n);
      repeat (n) step();
    endtask

    task automatic issue(input logic [L-1:0][7:0] v);
      rdy = 1'b1;
      accept(v);
      step();
      rdy = 1'b0;
    endtask

    task automatic do_reset(input int n);
      rst_n = 1'b0;
      exp_q.delete();
      req_q.delete();
      fifo_q.delete();
      outstanding = 0;
      rdptr = 0;
      last_ev = -1000;
      idle(n);
      rst_n = 1'b1;
    endtask

    // Monitor, scoreboard and upstream FIFO model, all sampled mid-cycle.
    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        checks++;
        if (req || ptr_rst || vld || idx != 3'd0 || val != 8'sd0) begin
          errors++;
          $display("FAIL reset_outputs cfg%0d cyc %0d: req=%0b rew=%0b vld=%0b idx=%0d val=%0d, required all 0",
                   gi, cyc, req, ptr_rst, vld, idx, val);
        end
        last_idx = 0;
        last_val = 0;
      end else begin
        while (req_q.size() > 0 && req_q[0] < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_req cfg%0d cyc %0d: no req_chunk_in seen, required at cyc %0d", gi, cyc, req_q[0]);
          void'(req_q.pop_front());
        end
        if (req) begin
          checks++;
          if (req_q.size() == 0 || req_q[0] != cyc) begin
            errors++;
            $display("FAIL req_timing cfg%0d: req_chunk_in at cyc %0d, required at cyc %0d",
                     gi, cyc, (req_q.size() > 0) ? req_q[0] : -1);
          end else begin
            void'(req_q.pop_front());
          end
          if (fifo_q.size() > 0 && rdptr < C) begin
            for (int k = 0; k < WR; k++) data[k] = fifo_q[0][rdptr * WR + k];
            rdptr++;
          end
        end
        checks++;
        if (ptr_rst !== vld) begin
          errors++;
          $display("FAIL rewind_align cfg%0d cyc %0d: req_chunk_ptr_rst=%0b, required %0b (equal to out_vector_valid)",
                   gi, cyc, ptr_rst, vld);
        end
        if (vld) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid cfg%0d cyc %0d: out_vector_valid=1, required 0", gi, cyc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("cfg%0d cyc %0d: argmax_idx=%0d argmax_val=%0d (expected %0d/%0d at cyc %0d)",
                     gi, cyc, idx, val, e.idx, e.val, e.cyc);
            checks++;
            if (e.cyc != cyc) begin
              errors++;
              $display("FAIL valid_latency cfg%0d: valid at cyc %0d, required cyc %0d", gi, cyc, e.cyc);
            end
            checks++;
            if (int'(idx) != e.idx) begin
              errors++;
              $display("FAIL argmax_idx cfg%0d cyc %0d: got %0d, required %0d", gi, cyc, idx, e.idx);
            end
            checks++;
            if (int'(val) != e.val) begin
              errors++;
              $display("FAIL argmax_val cfg%0d cyc %0d: got %0d, required %0d", gi, cyc, val, e.val);
            end
            outstanding--;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            rdptr = 0;
          end
          last_idx = e_hold_idx(idx);
          last_val = int'(val);
        end else begin
          checks++;
          if (int'(idx) != last_idx || int'(val) != last_val) begin
            errors++;
            $display("FAIL output_hold cfg%0d cyc %0d: idx=%0d val=%0d, required held %0d/%0d",
                     gi, cyc, idx, val, last_idx, last_val);
          end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_valid cfg%0d cyc %0d: no out_vector_valid, required at cyc %0d", gi, cyc, exp_q[0].cyc);
          void'(exp_q.pop_front());
          outstanding--;
          if (fifo_q.size() > 0) void'(fifo_q.pop_front());
          rdptr = 0;
        end
      end
    end

    function automatic int e_hold_idx(input logic [2:0] i);
      return int'(i);
    endfunction

    initial begin
      rdy   = 1'b0;
      data  = '0;
      rst_n = 1'b0;
      do_reset(3);
      idle(2);
      if (gi == 0) begin
        issue(mk(0, 0, 0, 0, 1, 3, 5, 7));            idle(6);
        issue(mk(0, 0, 0, 0, 0, 0, 0, 0));            idle(6);
        issue(mk(-128, -128, -128, -128, -128, -128, -128, -128)); idle(6);
        issue(mk(4, 9, -3, 9, 0, 1, 2, 3));           idle(2);
        issue(mk(-7, -2, -9, -2, -100, -1, -5, -1));  idle(6);
        issue(mk(1, 2, 3, 4, 5, 6, 7, 8));
        issue(mk(50, -50, 60, 60, 1, 1, 1, 1));
        issue(mk(127, 127, 127, 127, 127, 127, 127, 127));
        idle(10);
      end else begin
        issue(mk(-5, 2, 9, 9, 9, -1, 0, 3));          idle(8);
        issue(mk(10, 20, 30, 40, 50, 60, 70, 80));    idle(8);
        issue(mk(1, 2, 3, 4, 99, 6, 7, 8));           idle(1);
        do_reset(1);
        issue(mk(-3, -3, 4, -128, 127, 0, 127, 5));   idle(8);
      end
      for (int n = 0; n < 150; n++) begin
        issue(rand_vec());
        if (gi == 1 && $urandom % 100 < 4) do_reset(1 + int'($urandom % 2));
        idle(int'($urandom_range(0, 2 * C + 3)));
      end
      for (int w = 0; w < 200 && outstanding > 0; w++) step();
      if (outstanding > 0) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout cfg%0d: %0d results outstanding, required 0", gi, outstanding);
      end
      idle(4);
      done_flag = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 60000 && !(g_cfg[0].done_flag && g_cfg[1].done_flag); i++) @(posedge clk);
    if (!(g_cfg[0].done_flag && g_cfg[1].done_flag)) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: stimulus not finished, required completion within 60000 cycles");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
